// File: rtl/cpu_trace_fifo_if.sv
// Trace-capture bus: CPU observation inputs, reader handshake, and status outputs.
// Slave modport belongs to cpu_trace_fifo. Master modport belongs to the CPU/reader side.
interface cpu_trace_fifo_if #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic             i_trace_valid;
  logic [31:0]      i_trace_pc;
  logic [31:0]      i_trace_instr;
  logic [4:0]       i_trace_rd;
  logic [31:0]      i_trace_db;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [31:0]      o_out_pc;
  logic [31:0]      o_out_instr;
  logic [4:0]       o_out_rd;
  logic [31:0]      o_out_db;
  logic [SEQ_W-1:0] o_out_seq;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic [7:0]       o_drop_cnt;
  logic             i_clr_ovf;

  modport slave (
    input  i_trace_valid, i_trace_pc, i_trace_instr, i_trace_rd, i_trace_db,
    input  i_out_ready, i_clr_ovf,
    output o_out_valid, o_out_pc, o_out_instr, o_out_rd, o_out_db, o_out_seq,
    output o_level, o_overflow, o_drop_cnt
  );

  modport master (
    output i_trace_valid, i_trace_pc, i_trace_instr, i_trace_rd, i_trace_db,
    output i_out_ready, i_clr_ovf,
    input  o_out_valid, o_out_pc, o_out_instr, o_out_rd, o_out_db, o_out_seq,
    input  o_level, o_overflow, o_drop_cnt
  );
endinterface

// File: rtl/cpu_trace_fifo.sv
// Commit-trace capture FIFO: tags each observed CPU record with a sequence number and buffers it for a reader.
// Optional macro TRACE_FILTER_EN suppresses consecutive records that repeat the same PC.
module cpu_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  cpu_trace_fifo_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic [31:0]      db;
    logic [SEQ_W-1:0] seq;
  } trace_rec_t;

  trace_rec_t       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [SEQ_W-1:0] r_seq;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic       w_observed;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  trace_rec_t w_head;
  trace_rec_t w_new;

`ifdef TRACE_FILTER_EN
  logic [31:0] r_last_pc;
  logic        r_last_pc_vld;

  // Stalls repeat the same PC. Only the first occurrence counts as an observed record.
  assign w_observed = bus.i_trace_valid && !(r_last_pc_vld && (bus.i_trace_pc == r_last_pc));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_pc     <= '0;
      r_last_pc_vld <= 1'b0;
    end else if (bus.i_trace_valid) begin
      r_last_pc     <= bus.i_trace_pc;
      r_last_pc_vld <= 1'b1;
    end
  end
`else
  assign w_observed = bus.i_trace_valid;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.i_out_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push  = w_observed && (!w_full || w_pop);
  assign w_drop  = w_observed && w_full && !w_pop;

  assign w_new = '{pc: bus.i_trace_pc, instr: bus.i_trace_instr, rd: bus.i_trace_rd,
                   db: bus.i_trace_db, seq: r_seq};

  // NOTE: storage has no reset. The pointers alone define which entries are live, so resetting the array would only add logic.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_new;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_seq    <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_observed) r_seq    <= r_seq + 1'b1;
    end
  end

  // A drop in the same cycle as a clear wins, so the clear restarts the count at one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.i_clr_ovf)            r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (bus.i_clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  // Head fields read zero while the FIFO is empty, so stale storage never shows on the outputs.
  assign bus.o_out_valid = !w_empty;
  assign bus.o_out_pc    = w_empty ? '0 : w_head.pc;
  assign bus.o_out_instr = w_empty ? '0 : w_head.instr;
  assign bus.o_out_rd    = w_empty ? '0 : w_head.rd;
  assign bus.o_out_db    = w_empty ? '0 : w_head.db;
  assign bus.o_out_seq   = w_empty ? '0 : w_head.seq;
  assign bus.o_level     = r_wr_ptr - r_rd_ptr;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_drop_cnt  = r_drop_cnt;
endmodule

// File: doc/cpu_trace_fifo.md
# cpu_trace_fifo

Commit-trace capture buffer for the five-stage pipeline CPU. Samples the CPU's observation bus (current PC, instruction, destination register, DB write-back data) whenever a record is flagged valid, tags each record with a sequence number, and buffers it in a FIFO. A downstream reader (bench checker, UART dumper or logic analyser port) drains records over a valid/ready handshake. It is the consuming end of the CPU debug outputs: the CPU writes the trace and this block hands it to a reader.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- SEQ_W, 16, sequence-number width
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- trace_valid  in  1  record present on trace_* this cycle
- trace_pc  in  32  curPC of the record
- trace_instr  in  32  instruction word
- trace_rd  in  5  destination register address
- trace_db  in  32  DB bus (write-back) data
- out_valid  out  1  head record available
- out_ready  in  1  reader accepts head record
- out_pc / out_instr / out_rd / out_db  out  32/32/5/32  head record fields
- out_seq  out  SEQ_W  sequence number of head record
- level  out  $clog2(DEPTH)+1  entries currently stored
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  8  dropped records, saturates at 255
- clr_ovf  in  1  clears overflow and drop_cnt

## Operation
- Observed record: trace_valid=1 (and not filtered, see Configuration). Each observed record consumes one sequence number; seq counter wraps modulo 2^SEQ_W.
- Push: observed record written at tail when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Drop: observed record with level==DEPTH and no pop that cycle -> not stored, overflow<=1, drop_cnt+1 (saturating). Seq still advances, so gaps in out_seq identify drops.
- Pop: out_valid && out_ready; head advances. out_ready ignored when out_valid=0.
- Pointers are log2(DEPTH)+1 bits; empty = pointers equal, full = MSB differ, rest equal; wrap is natural modulo.
- Simultaneous push+pop: level unchanged; allowed at empty (push only, since out_valid=0) and at full.
- clr_ovf: overflow<=0, drop_cnt<=0 next edge; if a drop occurs in the same cycle, the drop wins (overflow=1, drop_cnt=1).
- Reset (any time, including mid-stream): pointers, level, seq, overflow, drop_cnt to 0; stored records discarded; memory contents need not be cleared.

## Timing
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, out_seq=0; out_pc/out_instr/out_rd/out_db=0 while empty.
- Push latency: record sampled at edge k appears on out_* with out_valid=1 after edge k (visible in cycle k+1); level updates at the same edge.
- out_* show-ahead: head fields valid combinationally from storage whenever out_valid=1; they stay stable until the pop edge.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from out_ready to out_valid or from trace_* to out_*.

## Configuration
- TRACE_FILTER_EN defined: block keeps last_pc and last_pc_vld (last_pc_vld cleared by reset). A trace_valid record whose trace_pc equals last_pc while last_pc_vld=1 is suppressed: not pushed, no seq increment, no drop counted. last_pc updates on every trace_valid, so pipeline stalls repeating a PC produce one record. First record after reset always passes.
- Not defined: every trace_valid cycle is an observed record; no last_pc state exists.

## Test plan
- Reset release, trace_valid pulses with pc=0x0,0x4,0x8, out_ready=1 -> three records out in order, out_seq=0,1,2, level returns to 0, overflow=0.
- DEPTH=16, out_ready=0, 20 consecutive records -> level=16, overflow=1, drop_cnt=4; drain shows out_seq 0..15; next accepted record has out_seq=20.
- Full FIFO, trace_valid and out_ready both 1 for 5 cycles -> level stays 16, drop_cnt unchanged, records accepted.
- clr_ovf pulse after overflow -> overflow=0, drop_cnt=0; clr_ovf coincident with a drop -> overflow=1, drop_cnt=1.
- Reset asserted low with level=7 mid-drain -> out_valid=0, level=0, out_seq=0 immediately (asynchronous); first record after release has out_seq=0.
- TRACE_FILTER_EN: pc sequence 0x10,0x10,0x10,0x14,0x10 -> three records, pc 0x10,0x14,0x10, out_seq 0,1,2; without the macro -> five records, seq 0..4.
